// File: rtl/sccb_write_master.sv
// SCCB/I2C write master for the OV7670 configuration path.
// Each accepted 16-bit word {register address, register value} becomes one
// 3-phase write: START, device address, register address, value, STOP.
// Both bus lines are open-drain: they are driven low or released (high-Z).
module sccb_write_master #(
    parameter int unsigned CLK_DIV     = 250,
    parameter logic [7:0]  DEVICE_ADDR = 8'h42,
    parameter bit          CHECK_ACK   = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] write_data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        error_o,
    inout  wire         sda_io,
    output logic        scl_o
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [4:0]  LAST_SLOT = 5'd26;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BITS, S_STOP} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_div, w_div_nxt;
    logic [4:0]  r_slot, w_slot_nxt;
    logic [1:0]  r_qtr, w_qtr_nxt;
    logic        r_err, w_err_nxt;
    logic        r_done, w_done_nxt;
    logic        r_nack, w_nack_nxt;
    logic        r_sda_low, w_sda_low_nxt;
    logic        r_scl_low, w_scl_low_nxt;
    logic [15:0] r_data;

    logic        w_tick;
    logic        w_accept;
    logic        w_ack_slot;
    logic        w_sda_in;
    logic        w_next_bit;
    logic [4:0]  w_slot_inc;
    logic [26:0] w_frame;

    // ACK slots are sent as '1' so the master releases SDA for the slave.
    assign w_frame    = {DEVICE_ADDR, 1'b1, r_data[15:8], 1'b1, r_data[7:0], 1'b1};
    assign w_tick     = (r_div == DIV_LAST);
    assign w_accept   = (r_state == S_IDLE) && valid_i;
    assign w_slot_inc = r_slot + 5'd1;
    assign w_ack_slot = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == LAST_SLOT);
    assign w_next_bit = (r_slot == LAST_SLOT) ? 1'b1 : w_frame[LAST_SLOT - w_slot_inc];
    assign w_sda_in   = sda_io;

    assign ready_o = (r_state == S_IDLE);
    assign done_o  = r_done;
    assign error_o = r_err;
    assign sda_io  = r_sda_low ? 1'b0 : 1'bz;
    assign scl_o   = r_scl_low ? 1'b0 : 1'bz;

    // Control registers; reset releases both bus lines at once, no STOP is sent
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_slot    <= '0;
            r_qtr     <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
            r_sda_low <= 1'b0;
            r_scl_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_slot    <= w_slot_nxt;
            r_qtr     <= w_qtr_nxt;
            r_err     <= w_err_nxt;
            r_done    <= w_done_nxt;
            r_nack    <= w_nack_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_scl_low <= w_scl_low_nxt;
        end
    end

    // Request word is captured only on accept and held for the whole write
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_data <= write_data_i;
        end
    end

    // Sequencer: every bus change happens on a quarter tick
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = (r_state == S_IDLE || w_tick) ? 16'd0 : r_div + 16'd1;
        w_slot_nxt    = r_slot;
        w_qtr_nxt     = r_qtr;
        w_err_nxt     = r_err;
        w_done_nxt    = 1'b0;
        w_nack_nxt    = r_nack;
        w_sda_low_nxt = r_sda_low;
        w_scl_low_nxt = r_scl_low;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_state_nxt   = S_START;
                    w_slot_nxt    = '0;
                    w_qtr_nxt     = '0;
                    w_err_nxt     = 1'b0;
                    w_nack_nxt    = 1'b0;
                    w_sda_low_nxt = 1'b0;
                    w_scl_low_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_qtr == 2'd0) begin
                        w_qtr_nxt     = 2'd1;
                        w_sda_low_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_BITS;
                        w_slot_nxt    = '0;
                        w_qtr_nxt     = 2'd0;
                        w_scl_low_nxt = 1'b1;
                        w_sda_low_nxt = ~w_frame[LAST_SLOT];
                    end
                end
            end
            S_BITS: begin
                if (w_tick) begin
                    case (r_qtr)
                        2'd0: w_qtr_nxt = 2'd1;
                        2'd1: begin
                            w_qtr_nxt     = 2'd2;
                            w_scl_low_nxt = 1'b0;
                        end
                        2'd2: begin
                            w_qtr_nxt = 2'd3;
                            // SDA left high in an ACK slot means the slave did not answer
                            if (CHECK_ACK && w_ack_slot && w_sda_in) begin
                                w_err_nxt  = 1'b1;
                                w_nack_nxt = 1'b1;
                            end
                        end
                        default: begin
                            w_qtr_nxt     = 2'd0;
                            w_scl_low_nxt = 1'b1;
                            if (r_slot == LAST_SLOT || r_nack) begin
                                w_state_nxt   = S_STOP;
                                w_sda_low_nxt = 1'b1;
                            end else begin
                                w_slot_nxt    = w_slot_inc;
                                w_sda_low_nxt = ~w_next_bit;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (w_tick) begin
                    case (r_qtr)
                        2'd0: begin
                            w_qtr_nxt     = 2'd1;
                            w_scl_low_nxt = 1'b0;
                        end
                        2'd1: begin
                            w_qtr_nxt     = 2'd2;
                            w_sda_low_nxt = 1'b0;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                            w_qtr_nxt   = 2'd0;
                            w_slot_nxt  = '0;
                            w_done_nxt  = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master with CLK_DIV=4.
// Bus A has an ACK-capable slave model; bus B has no slave (CHECK_ACK=0 instance).
module tb_sccb_write_master;

    localparam int CLK_DIV = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_a  = '0;
    logic [15:0] data_b  = '0;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_a, done_a, error_a;
    logic        ready_b, done_b, error_b;
    wire         sda_a, scl_a, sda_b, scl_b;

    pullup pu_sda_a (sda_a);
    pullup pu_scl_a (scl_a);
    pullup pu_sda_b (sda_b);
    pullup pu_scl_b (scl_b);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sccb_write_master #(.CLK_DIV(CLK_DIV), .DEVICE_ADDR(8'h42), .CHECK_ACK(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_n), .write_data_i(data_a), .valid_i(valid_a),
        .ready_o(ready_a), .done_o(done_a), .error_o(error_a), .sda_io(sda_a), .scl_o(scl_a)
    );

    sccb_write_master #(.CLK_DIV(CLK_DIV), .DEVICE_ADDR(8'h42), .CHECK_ACK(1'b0)) dut_na (
        .clk_i(clk), .reset_i(reset_n), .write_data_i(data_b), .valid_i(valid_b),
        .ready_o(ready_b), .done_o(done_b), .error_o(error_b), .sda_io(sda_b), .scl_o(scl_b)
    );

    // Slave model A: detects START, captures SDA on SCL rise, ACKs selected slots
    logic [2:0]  ack_mask   = 3'b111;
    logic        prev_scl_a = 1'b1;
    logic        prev_sda_a = 1'b1;
    logic        drv_low    = 1'b0;
    int          slot_a     = 99;
    int          rises_a    = 0;
    int          stops_a    = 0;
    logic [27:0] cap_a      = '0;

    assign sda_a = drv_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        prev_scl_a <= scl_a;
        prev_sda_a <= sda_a;
        if (prev_scl_a && scl_a && prev_sda_a && !sda_a) begin
            slot_a  <= -1;
            rises_a <= 0;
            stops_a <= 0;
            cap_a   <= '0;
            drv_low <= 1'b0;
        end else begin
            if (prev_scl_a && !scl_a) begin
                slot_a  <= slot_a + 1;
                drv_low <= ((slot_a + 1 == 8)  && ack_mask[0]) ||
                           ((slot_a + 1 == 17) && ack_mask[1]) ||
                           ((slot_a + 1 == 26) && ack_mask[2]);
            end
            if (!prev_scl_a && scl_a) begin
                rises_a <= rises_a + 1;
                cap_a   <= {cap_a[26:0], sda_a};
            end
            if (prev_scl_a && scl_a && !prev_sda_a && sda_a) stops_a <= stops_a + 1;
        end
    end

    // Passive monitor B: captures SDA on SCL rise, never drives the bus
    logic        prev_scl_b = 1'b1;
    logic        prev_sda_b = 1'b1;
    int          rises_b    = 0;
    logic [27:0] cap_b      = '0;

    always @(negedge clk) begin
        prev_scl_b <= scl_b;
        prev_sda_b <= sda_b;
        if (prev_scl_b && scl_b && prev_sda_b && !sda_b) begin
            rises_b <= 0;
            cap_b   <= '0;
        end else if (!prev_scl_b && scl_b) begin
            rises_b <= rises_b + 1;
            cap_b   <= {cap_b[26:0], sda_b};
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Expected SCL-rise capture: bits of the frame up to the last slot, then the STOP rise (SDA=0)
    function automatic logic [27:0] exp_cap(input logic [15:0] d, input logic [2:0] ack, input int slots);
        logic [27:0] full;
        full = {8'h42, ~ack[0], d[15:8], ~ack[1], d[7:0], ~ack[2], 1'b0};
        return full >> (27 - slots);
    endfunction

    task automatic wait_done_a(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 1000; i++) begin
            if (done_a) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_write(input string tag, input logic [15:0] d, input logic [2:0] ack,
                             input logic exp_err, input int exp_lat, input int slots);
        int t0, lat;
        ack_mask = ack;
        @(negedge clk);
        data_a  = d;
        valid_a = 1'b1;
        @(negedge clk);
        t0      = cyc;
        valid_a = 1'b0;
        check($sformatf("%s ready low after accept", tag), ready_a, 0);
        check($sformatf("%s error cleared on accept", tag), error_a, 0);
        wait_done_a(t0, lat);
        check($sformatf("%s done latency", tag), lat, exp_lat);
        check($sformatf("%s ready in done cycle", tag), ready_a, 1);
        check($sformatf("%s error", tag), error_a, exp_err);
        @(negedge clk);
        check($sformatf("%s done one cycle", tag), done_a, 0);
        repeat (20) @(negedge clk);
        check($sformatf("%s scl rises", tag), rises_a, slots + 1);
        check($sformatf("%s captured bits", tag), cap_a, exp_cap(d, ack, slots));
        check($sformatf("%s stop count", tag), stops_a, 1);
        check($sformatf("%s scl idle", tag), scl_a, 1);
        check($sformatf("%s sda idle", tag), sda_a, 1);
        check($sformatf("%s error held", tag), error_a, exp_err);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [2:0]  ack;
        logic        exp_err;
        int          exp_lat;
        int          slots;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int t0, t1, t2, lat, bad_ready, done_seen;

        vecs[0] = '{16'h1280, 3'b111, 1'b0, 452, 27};
        vecs[1] = '{16'h1104, 3'b111, 1'b0, 452, 27};
        vecs[2] = '{16'hFF00, 3'b111, 1'b0, 452, 27};
        vecs[3] = '{16'h00FF, 3'b111, 1'b0, 452, 27};
        vecs[4] = '{16'h1280, 3'b000, 1'b1, 164,  9};
        vecs[5] = '{16'h3A5C, 3'b001, 1'b1, 308, 18};
        vecs[6] = '{16'h3A5C, 3'b011, 1'b1, 452, 27};
        vecs[7] = '{16'h1280, 3'b111, 1'b0, 452, 27};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset ready", ready_a, 1);
        check("reset done", done_a, 0);
        check("reset error", error_a, 0);
        check("reset scl", scl_a, 1);
        check("reset sda", sda_a, 1);
        check("reset ready b", ready_b, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle ready", ready_a, 1);

        for (int i = 0; i < 8; i++) begin
            run_write($sformatf("v%0d", i), vecs[i].data, vecs[i].ack,
                      vecs[i].exp_err, vecs[i].exp_lat, vecs[i].slots);
        end

        // Back-to-back: valid held high, second word accepted in the done cycle
        ack_mask = 3'b111;
        @(negedge clk);
        data_a  = 16'h1280;
        valid_a = 1'b1;
        @(negedge clk);
        t1 = cyc;
        wait_done_a(t1, lat);
        check("b2b first latency", lat, 452);
        check("b2b first capture", cap_a, exp_cap(16'h1280, 3'b111, 27));
        data_a = 16'h1104;
        @(negedge clk);
        t2      = cyc;
        valid_a = 1'b0;
        check("b2b second accepted", ready_a, 0);
        repeat (CLK_DIV) @(negedge clk);
        check("b2b start sda low", sda_a, 0);
        check("b2b start scl high", scl_a, 1);
        wait_done_a(t2, lat);
        check("b2b second latency", lat, 452);
        repeat (20) @(negedge clk);
        check("b2b second capture", cap_a, exp_cap(16'h1104, 3'b111, 27));
        check("b2b idle after", ready_a, 1);

        // Toggling valid/data while busy must not disturb the latched word
        @(negedge clk);
        data_a  = 16'h1280;
        valid_a = 1'b1;
        @(negedge clk);
        t0        = cyc;
        lat       = -1;
        bad_ready = 0;
        for (int i = 0; i < 1000; i++) begin
            if (done_a) begin
                lat = cyc - t0;
                break;
            end
            if (ready_a) bad_ready++;
            valid_a = 1'(i & 1);
            data_a  = 16'($urandom);
            @(negedge clk);
        end
        valid_a = 1'b0;
        check("toggle latency", lat, 452);
        check("toggle ready while busy", bad_ready, 0);
        repeat (20) @(negedge clk);
        check("toggle capture", cap_a, exp_cap(16'h1280, 3'b111, 27));
        check("toggle no extra accept", ready_a, 1);

        // Asynchronous reset in the middle of a transfer
        @(negedge clk);
        data_a  = 16'h1280;
        valid_a = 1'b1;
        @(negedge clk);
        t0      = cyc;
        valid_a = 1'b0;
        while (cyc < t0 + 200) @(negedge clk);
        check("midreset scl low before", scl_a, 0);
        #1 reset_n = 1'b0;
        #1;
        check("midreset scl released", scl_a, 1);
        check("midreset sda released", sda_a, 1);
        check("midreset ready", ready_a, 1);
        check("midreset error", error_a, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        check("midreset no done", done_seen, 0);
        run_write("postreset", 16'h1104, 3'b111, 1'b0, 452, 27);

        // CHECK_ACK=0 instance: no slave answers, write still completes cleanly
        @(negedge clk);
        data_b  = 16'h1280;
        valid_b = 1'b1;
        @(negedge clk);
        t0      = cyc;
        valid_b = 1'b0;
        lat     = -1;
        for (int i = 0; i < 1000; i++) begin
            if (done_b) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check("noack latency", lat, 452);
        check("noack error", error_b, 0);
        check("noack ready", ready_b, 1);
        repeat (20) @(negedge clk);
        check("noack scl rises", rises_b, 28);
        check("noack capture", cap_b, exp_cap(16'h1280, 3'b000, 27));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
- Bit-level SCCB/I2C write engine for the OV7670 configuration path.
- Downstream of the configuration sequencer: accepts one 16-bit {register address, register value} word per valid/ready handshake.
- Emits one 3-phase write on the open-drain bus: START, device address, register address, data, STOP.
- Reports completion and NACK to the sequencer.

Parameters:
CLK_DIV, 250, clk_i cycles per SCL quarter-period (250 at 100 MHz gives 100 kHz SCL); legal range 2..65535
DEVICE_ADDR, 8'h42, 8-bit write address sent as the first byte (R/W bit included, LSB=0)
CHECK_ACK, 1, 1: sample all three ACK slots; 0: ignore all ACKs (SCCB don't-care mode)

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-low reset
write_data_i  input  16  [15:8] register address, [7:0] register value
valid_i  input  1  write request; sampled only when ready_o=1
ready_o  output  1  engine idle, able to accept a word
done_o  output  1  one-cycle pulse when a transaction (including an aborted one) completes
error_o  output  1  sticky NACK flag for the last transaction
sda_io  inout  1  open-drain data line: drives 0 or 'z only
scl_o  output  1  open-drain clock line: drives 0 or 'z only

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state=IDLE, divider=0, bit counter=0.
  - ready_o=1, done_o=0, error_o=0.
  - sda_io='z and scl_o='z immediately, including mid-transfer.
  - No STOP is generated; the bus is simply released.
- Accept:
  - Accept occurs on the clk_i edge where valid_i=1 and ready_o=1.
  - On accept: latch write_data_i, clear error_o, zero the quarter divider.
  - ready_o drops the next cycle; valid_i is ignored while ready_o=0.
- Quarter tick:
  - Generated every CLK_DIV cycles from the accept edge.
  - All bus changes occur on ticks.
- States: IDLE -> START -> BITS -> STOP -> IDLE.
- START (2 quarters):
  - q0: SDA=z, SCL=z.
  - q1: SDA=0, SCL=z.
- BITS (27 slots of 4 quarters each):
  - Slot order: DEVICE_ADDR MSB-first, ACK, reg addr MSB-first, ACK, value MSB-first, ACK.
  - Per slot: q0 SCL=0, SDA updated (bit '1' -> z, '0' -> 0, ACK slot -> z); q1 SCL=0; q2 SCL=z; q3 SCL=z.
- ACK sampling:
  - Sampled at the end of q2 of each ACK slot.
  - With CHECK_ACK=1, sampled SDA=1 is a NACK: set error_o and go to STOP after that slot, skipping the remaining bytes.
- STOP (3 quarters):
  - q0: SCL=0, SDA=0.
  - q1: SCL=z, SDA=0.
  - q2: SCL=z, SDA=z.
- Completion:
  - After the final STOP quarter: done_o=1 for exactly one cycle, ready_o=1 in the same cycle, state=IDLE.
  - Full transaction: done_o rises 113*CLK_DIV cycles after the accept edge (2+108+3 quarters).
  - NACK on slot k (k=9, 18, or 27): done_o rises (2+4k+3)*CLK_DIV cycles after accept.
- Back-to-back: valid_i=1 in the done_o cycle is accepted; the next START begins with no idle quarters.
- error_o holds its value until the next accept or reset.
- Counter widths: divider 16 bits; slot counter 5 bits; quarter counter 2 bits; no wrap-around within a legal transaction.

Test Plan:
1. CLK_DIV=4, slave ACKs all, write 16'h1280:
   - SDA bits sampled at SCL rise are 0x42, ACK, 0x12, ACK, 0x80, ACK.
   - done_o pulses at cycle 452; error_o=0; ready_o back to 1.
2. Slave NACKs the device address:
   - error_o=1, STOP emitted immediately.
   - done_o at (2+36+3)*4 = 164 cycles; no further SCL pulses.
3. Two words 16'h1280, 16'h1104, valid_i held high:
   - Second accept occurs in the first done_o cycle.
   - Second START follows immediately; two done_o pulses 452 cycles apart.
4. reset_i low at cycle 200 of a transfer:
   - SCL/SDA go 'z asynchronously, ready_o=1.
   - No done_o pulse; a new write after release completes normally.
5. valid_i toggled with new data while busy:
   - Latched word is unchanged; no extra accept until ready_o=1.
6. CHECK_ACK=0, slave leaves SDA high on every ACK slot:
   - Full 113-quarter transaction completes; error_o=0.
